user_uart_tx: RTL and testbench

Byte-stream UART transmitter (8N1, LSB first) for the user project area. It drives the serial line that the management-side testbench UART monitors on mprj_io[6]. Firmware or user logic pushes bytes through a valid/ready port into a small FIFO. A baud-rate divider and a frame state machine then serialize each byte onto `tx`.

---
 rtl/user_uart_tx.sv | 148 ++++++++++++++
 tb/tb_user_uart_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_uart_tx.sv
// 8N1 LSB-first UART transmitter with a small byte FIFO in front of the frame FSM.
// The serial output is registered and the bit period is sampled once per frame.
module user_uart_tx #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             tx_en,
  input  logic [15:0]      clk_div,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      bit_div_q, bit_div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [7:0]       mem_q [DEPTH];

  logic empty, full, push, pop, bit_done, can_start;

  assign empty     = (count_q == '0);
  assign full      = (count_q == LVL_W'(DEPTH));
  assign push      = tx_valid && !full;
  assign bit_done  = (cnt_q == bit_div_q);
  assign can_start = tx_en && !empty;

  assign tx_ready   = !full;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign fifo_level = count_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_div_d = bit_div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop       = 1'b1;
          state_d   = S_START;
          cnt_d     = '0;
          bit_idx_d = '0;
          shift_d   = mem_q[rd_ptr_q];
          bit_div_d = clk_div;
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          // Chain straight into the next frame so a queued byte costs no idle cycle.
          if (can_start) begin
            pop       = 1'b1;
            state_d   = S_START;
            bit_idx_d = '0;
            shift_d   = mem_q[rd_ptr_q];
            bit_div_d = clk_div;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line level is derived from the next state so tx leaves a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // Payload storage carries no reset; control state alone decides what is valid.
  always_ff @(posedge wb_clk_i) begin
    shift_q   <= shift_d;
    bit_div_q <= bit_div_d;
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_user_uart_tx.sv
// Scoreboard bench for user_uart_tx: stimulus queues expected frames, a line monitor decodes tx.
module tb_user_uart_tx;

  logic        clk;
  logic        wb_rst_i;
  logic        tx_en;
  logic [15:0] clk_div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  typedef struct {
    logic [7:0] b;
    int         p;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   frames_done = 0;

  user_uart_tx #(.DEPTH(4), .LVL_W(3)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .tx_en     (tx_en),
    .clk_div   (clk_div),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b, input int p);
    int   w;
    exp_t e;
    e.b = b;
    e.p = p;
    exp_q.push_back(e);
    tx_data  = b;
    tx_valid = 1'b1;
    w = 0;
    while (!tx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) chk("push_timeout_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int w;
    w = 0;
    while (busy && w < lim) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout_busy", 32'(busy), 32'd0);
  endtask

  // Line monitor: decodes each frame at mid-bit using the period queued with it.
  initial begin
    logic [9:0] got;
    exp_t       e;
    int         p;
    int         w;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!wb_rst_i && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got start bit, expected idle line");
          w = 0;
          while (tx === 1'b0 && !wb_rst_i && w < 1000) begin
            @(negedge clk);
            w++;
          end
        end else begin
          e   = exp_q.pop_front();
          p   = e.p;
          ab  = 1'b0;
          got = '0;
          for (int c = 0; c < 10 * p; c++) begin
            if (c > 0) @(negedge clk);
            if (wb_rst_i) begin
              ab = 1'b1;
              break;
            end
            if (c % p == p / 2) got[c / p] = tx;
          end
          if (!ab) begin
            frames_done++;
            chk("frame_bits", 32'(got), 32'({1'b1, e.b, 1'b0}));
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int nb;
    exp_t e;

    wb_rst_i = 1'b1;
    tx_en    = 1'b0;
    clk_div  = 16'd0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    // Reset values and idle line
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("idle_100_lows", 32'(lows), 32'd0);

    // Single byte, 4-cycle bits
    tx_en   = 1'b1;
    clk_div = 16'd3;
    push(8'hA5, 4);
    chk("single_level_after_push", 32'(fifo_level), 32'd1);
    chk("single_busy_after_push", 32'(busy), 32'd1);
    chk("single_tx_before_pop", 32'(tx), 32'd1);
    @(negedge clk);
    chk("single_start_latency", 32'(tx), 32'd0);
    chk("single_level_after_pop", 32'(fifo_level), 32'd0);
    nb = 1;
    while (nb < 500) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    chk("single_frame_len", 32'(nb), 32'd40);

    // Fill the FIFO while gated, then run five frames back-to-back
    tx_en   = 1'b0;
    clk_div = 16'd0;
    push(8'h00, 1);
    push(8'hFF, 1);
    push(8'h55, 1);
    push(8'h0F, 1);
    chk("fill_level_full", 32'(fifo_level), 32'd4);
    chk("fill_ready_full", 32'(tx_ready), 32'd0);
    e.b = 8'hC3;
    e.p = 1;
    exp_q.push_back(e);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fill_fifth_held", 32'({tx_ready, fifo_level}), 32'({1'b0, 3'd4}));
    end
    tx_en = 1'b1;
    @(negedge clk);
    chk("fill_first_start", 32'(tx), 32'd0);
    chk("fill_ready_after_pop", 32'({tx_ready, fifo_level}), 32'({1'b1, 3'd3}));
    nb = 1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("fill_fifth_accepted", 32'({tx_ready, fifo_level}), 32'({1'b0, 3'd4}));
    if (busy) nb++;
    while (nb < 500) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    chk("fill_busy_cycles", 32'(nb), 32'd50);

    // tx_en dropped during bit 3 of frame 1
    clk_div = 16'd1;
    push(8'h81, 2);
    push(8'h7E, 2);
    chk("gate_frame1_started", 32'(tx), 32'd0);
    repeat (8) @(negedge clk);
    tx_en = 1'b0;
    repeat (12) @(negedge clk);
    chk("gate_idle_tx", 32'(tx), 32'd1);
    chk("gate_level_retained", 32'(fifo_level), 32'd1);
    chk("gate_busy_retained", 32'(busy), 32'd1);
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("gate_hold_lows", 32'(lows), 32'd0);
    tx_en = 1'b1;
    @(negedge clk);
    chk("gate_resume_start", 32'(tx), 32'd0);
    chk("gate_resume_level", 32'(fifo_level), 32'd0);
    wait_idle(100);

    // clk_div changed mid-frame only affects the next frame
    push(8'h3C, 2);
    push(8'h96, 8);
    repeat (4) @(negedge clk);
    clk_div = 16'd7;
    wait_idle(300);
    chk("div_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 4 with two bytes queued
    clk_div = 16'd1;
    push(8'h11, 2);
    push(8'h22, 2);
    push(8'h33, 2);
    chk("rst_mid_level", 32'(fifo_level), 32'd2);
    repeat (9) @(negedge clk);
    wb_rst_i = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_level0", 32'(fifo_level), 32'd0);
    chk("rst_mid_ready", 32'(tx_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("rst_mid_no_frames", 32'(lows), 32'd0);
    chk("rst_mid_busy_after", 32'(busy), 32'd0);

    chk("frames_completed", 32'(frames_done), 32'd10);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
